// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART TX and RX paths.
//   tlen_e     : character length encoding (5..8 data bits)
//   rx_state_e : receive engine states
//   OSR16/13   : oversampling ratios selected by bclk_mode
//   nbits()    : number of data bits for a tlen code
package uart_pkg;

  typedef enum logic [1:0] {
    TLEN_5 = 2'b00,
    TLEN_6 = 2'b01,
    TLEN_7 = 2'b10,
    TLEN_8 = 2'b11
  } tlen_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  localparam int unsigned OSR16 = 16;
  localparam int unsigned OSR13 = 13;

  function automatic logic [3:0] nbits(input tlen_e tlen);
    return 4'd5 + {2'b00, tlen};
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversample tick generator, one tick every baud_div+1 clks.
//   clk, rst  : clock, synchronous active-high reset (clears the counter)
//   baud_div  : tick period minus one (not latched; may change at any time)
//   tick      : one-cycle tick strobe
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // >= rather than == so a divisor lowered below the running count
  // does not force a full counter wrap.
  assign tick = (cnt >= baud_div);

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receive engine, 5..8 data bits, optional parity,
// x16 / x13 oversampling.
//   clk, rst      : clock, synchronous active-high reset
//   baud_div      : oversample tick period minus one
//   bclk_mode     : 0 = x16, 1 = x13 oversampling
//   tlen          : data length code (5 + tlen bits)
//   parity_en     : parity bit present
//   parity_type   : 0 = even, 1 = odd
//   rxd           : asynchronous serial input, idle high
//   rdata         : received character, zero-extended
//   rx_valid      : one-cycle strobe, character complete
//   parity_err    : parity mismatch for the flagged character
//   frame_err     : stop bit sampled low for the flagged character
//   rx_busy       : engine not idle
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             bclk_mode,
  input  logic [1:0]       tlen,
  input  logic             parity_en,
  input  logic             parity_type,
  input  logic             rxd,
  output logic [7:0]       rdata,
  output logic             rx_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             rx_busy
);

  logic tick;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .baud_div (baud_div),
    .tick     (tick)
  );

  // 2-flop synchroniser, idle-high reset so reset never looks like a start bit
  logic rxd_m, rxd_s;
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  rx_state_e  state, state_n;
  logic [3:0] os_cnt, os_cnt_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic       par_bit, par_bit_n;
  // frame configuration captured at start detection
  logic [3:0] nbits_q, nbits_n;
  logic       par_en_q, par_en_n;
  logic       par_type_q, par_type_n;
  logic [3:0] os_last_q, os_last_n;
  logic [3:0] os_mid_q, os_mid_n;
  logic [7:0] rdata_n;
  logic       rx_valid_n, parity_err_n, frame_err_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      nbits_q    <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      os_last_q  <= '0;
      os_mid_q   <= '0;
      rdata      <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      os_cnt     <= os_cnt_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      par_bit    <= par_bit_n;
      nbits_q    <= nbits_n;
      par_en_q   <= par_en_n;
      par_type_q <= par_type_n;
      os_last_q  <= os_last_n;
      os_mid_q   <= os_mid_n;
      rdata      <= rdata_n;
      rx_valid   <= rx_valid_n;
      parity_err <= parity_err_n;
      frame_err  <= frame_err_n;
    end
  end

  // a full bit period has elapsed since the previous mid-bit sample
  logic bit_done;
  assign bit_done = tick && (os_cnt == os_last_q);

  always_comb begin
    state_n      = state;
    os_cnt_n     = os_cnt;
    bit_cnt_n    = bit_cnt;
    shreg_n      = shreg;
    par_bit_n    = par_bit;
    nbits_n      = nbits_q;
    par_en_n     = par_en_q;
    par_type_n   = par_type_q;
    os_last_n    = os_last_q;
    os_mid_n     = os_mid_q;
    rdata_n      = rdata;
    rx_valid_n   = 1'b0;
    parity_err_n = parity_err;
    frame_err_n  = frame_err;

    // count ticks within the bit; wrap is overridden below on sample ticks
    if (state != IDLE && state != BREAK && tick) os_cnt_n = os_cnt + 4'd1;

    unique case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_n    = START;
          os_cnt_n   = '0;
          nbits_n    = nbits(tlen_e'(tlen));
          par_en_n   = parity_en;
          par_type_n = parity_type;
          os_last_n  = bclk_mode ? 4'(OSR13 - 1) : 4'(OSR16 - 1);
          os_mid_n   = bclk_mode ? 4'(OSR13 / 2 - 1) : 4'(OSR16 / 2 - 1);
        end
      end
      START: begin
        if (tick && os_cnt == os_mid_q) begin
          if (!rxd_s) begin
            state_n   = DATA;
            os_cnt_n  = '0;
            bit_cnt_n = '0;
            shreg_n   = '0;   // bits above the character length stay zero
          end else begin
            state_n   = IDLE; // glitch, not a start bit
          end
        end
      end
      DATA: begin
        if (bit_done) begin
          os_cnt_n         = '0;
          shreg_n[bit_cnt] = rxd_s;
          if ({1'b0, bit_cnt} == nbits_q - 4'd1) begin
            bit_cnt_n = '0;
            state_n   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          os_cnt_n  = '0;
          par_bit_n = rxd_s;
          state_n   = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          os_cnt_n     = '0;
          rdata_n      = shreg;
          rx_valid_n   = 1'b1;
          // received bit vs. XOR(data) ^ parity_type
          parity_err_n = par_en_q & (par_bit ^ (^shreg) ^ par_type_q);
          frame_err_n  = !rxd_s;
          state_n      = rxd_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rxd_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames with hand-computed expected characters
// and flags for uart_rx_core.
module tb_uart_rx_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        bclk_mode;
  logic [1:0]  tlen;
  logic        parity_en, parity_type;
  logic        rxd;
  logic [7:0]  rdata;
  logic        rx_valid, parity_err, frame_err, rx_busy;

  uart_rx_core #(.DIV_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_div    (baud_div),
    .bclk_mode   (bclk_mode),
    .tlen        (tlen),
    .parity_en   (parity_en),
    .parity_type (parity_type),
    .rxd         (rxd),
    .rdata       (rdata),
    .rx_valid    (rx_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int strobes = 0;
  int bit_t;
  logic [7:0] cap_d;
  logic       cap_pe, cap_fe;

  // counts every cycle rx_valid is high, so a stuck strobe shows as >1
  always @(negedge clk) begin
    if (rx_valid) begin
      strobes++;
      cap_d  = rdata;
      cap_pe = parity_err;
      cap_fe = frame_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic b);
    rxd = b;
    repeat (bit_t) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen,
                            input bit ptype, input bit pflip, input bit stopv);
    logic [7:0] m;
    m = 8'((1 << nb) - 1);
    drive(1'b0);
    for (int i = 0; i < nb; i++) drive(d[i]);
    if (pen) drive((^(d & m)) ^ ptype ^ pflip);
    drive(stopv);
  endtask

  task automatic rx_frame(input string tag, input logic [7:0] d, input int nb,
                          input bit pen, input bit ptype, input bit pflip,
                          input logic [7:0] exp_d, input bit exp_pe);
    int s0;
    s0 = strobes;
    send_frame(d, nb, pen, ptype, pflip, 1'b1);
    drive(1'b1);
    chk({tag, "_strobes"}, strobes - s0, 1);
    chk({tag, "_rdata"}, cap_d, exp_d);
    chk({tag, "_perr"}, cap_pe, exp_pe);
    chk({tag, "_ferr"}, cap_fe, 0);
  endtask

  initial begin
    int s0;
    rst = 1'b1; rxd = 1'b1;
    baud_div = 16'd3; bclk_mode = 1'b0; tlen = 2'b11;
    parity_en = 1'b0; parity_type = 1'b0;
    bit_t = 16 * 4;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdata", rdata, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", rx_busy, 0);
    drive(1'b1);

    // 8N1 x16
    rx_frame("8n1", 8'hEB, 8, 0, 0, 0, 8'hEB, 0);
    chk("8n1_idle", rx_busy, 0);

    // 5/6/7 bit, no parity
    tlen = 2'b00; rx_frame("5n1", 8'hEB, 5, 0, 0, 0, 8'h0B, 0);
    tlen = 2'b01; rx_frame("6n1", 8'hEB, 6, 0, 0, 0, 8'h2B, 0);
    tlen = 2'b10; rx_frame("7n1", 8'hEB, 7, 0, 0, 0, 8'h6B, 0);

    // 8E1: 0xEA has five ones, even parity bit = 1
    tlen = 2'b11; parity_en = 1'b1; parity_type = 1'b0;
    rx_frame("8e1", 8'hEA, 8, 1, 0, 0, 8'hEA, 0);
    rx_frame("8e1_bad", 8'hEA, 8, 1, 0, 1, 8'hEA, 1);
    // odd parity, correct bit
    parity_type = 1'b1;
    rx_frame("8o1", 8'hEA, 8, 1, 1, 0, 8'hEA, 0);

    // x13
    parity_en = 1'b0; parity_type = 1'b0; bclk_mode = 1'b1;
    bit_t = 13 * 4;
    rx_frame("x13", 8'hAA, 8, 0, 0, 0, 8'hAA, 0);

    // stop bit low, then the line held low for 20 bit times
    s0 = strobes;
    send_frame(8'h3C, 8, 0, 0, 0, 1'b0);
    rxd = 1'b0;
    repeat (20 * bit_t) @(negedge clk);
    chk("brk_strobes", strobes - s0, 1);
    chk("brk_rdata", cap_d, 8'h3C);
    chk("brk_ferr", cap_fe, 1);
    chk("brk_busy", rx_busy, 1);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    chk("brk_release", rx_busy, 0);
    chk("brk_ferr_hold", frame_err, 1);
    drive(1'b1);

    // start-bit glitch: low for 3 ticks at x16
    bclk_mode = 1'b0; bit_t = 16 * 4;
    s0 = strobes;
    rxd = 1'b0;
    repeat (3 * 4) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * bit_t) @(negedge clk);
    chk("glitch_strobes", strobes - s0, 0);
    chk("glitch_busy", rx_busy, 0);

    // reset in the middle of data bit 4 of 0xFF
    s0 = strobes;
    drive(1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1);
    rxd = 1'b1;
    repeat (bit_t / 2) @(negedge clk);
    chk("pre_rst_busy", rx_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_rdata", rdata, 0);
    chk("mrst_valid", rx_valid, 0);
    chk("mrst_ferr", frame_err, 0);
    chk("mrst_perr", parity_err, 0);
    chk("mrst_busy", rx_busy, 0);
    repeat (2 * bit_t) @(negedge clk);
    chk("mrst_strobes", strobes - s0, 0);
    rx_frame("post_rst", 8'h55, 8, 0, 0, 0, 8'h55, 0);

    // tick every clk
    baud_div = 16'd0; bit_t = 16;
    rx_frame("div0", 8'hC3, 8, 0, 0, 0, 8'hC3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
